// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Issues one request at a time to instruction memory, feeds the IF/ID
// pipeline register, parks a word in a one-entry buffer while decode is
// stalled, discards responses made stale by a branch, and stops after HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mem_stall,
    input  logic        takeBranch,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_ID,
    output logic [15:0] PC_inc_ID,
    output logic        valid_ID,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALTED
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        drop, drop_nxt;
    logic [15:0] drop_addr, drop_addr_nxt;   // address of the request being discarded
    logic [15:0] hold_buf, hold_buf_nxt;
    logic        started;                     // low until the first edge after reset
    logic [15:0] instr_nxt, pc_inc_nxt;
    logic        valid_nxt;

    logic        if_en;
    logic        accept;
    logic        deliver;
    logic [15:0] deliver_word;

    // Outputs derived directly from state; the request address stays on the
    // stale PC until the discarded response has come back.
    assign imem_req  = started & (state == FETCH);
    assign imem_addr = drop ? drop_addr : pc;
    assign halted    = (state == HALTED);

    assign if_en  = ~stall & ~mem_stall;
    assign accept = imem_req & imem_ready & ~drop & ~takeBranch;

    // Next-state logic: branch redirect first, then word delivery or bubble.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt     = state;
        pc_nxt        = pc;
        drop_nxt      = drop;
        drop_addr_nxt = drop_addr;
        hold_buf_nxt  = hold_buf;
        instr_nxt     = instr_ID;
        pc_inc_nxt    = PC_inc_ID;
        valid_nxt     = valid_ID;
        deliver       = 1'b0;
        deliver_word  = hold_buf;

        if (takeBranch) begin
            pc_nxt        = branch_target;
            state_nxt     = FETCH;
            hold_buf_nxt  = '0;
            instr_nxt     = NOP_INSTR;
            valid_nxt     = 1'b0;
            // A request still waiting for its response must be drained;
            // one answered in this very cycle is simply ignored.
            drop_nxt      = imem_req & ~imem_ready;
            drop_addr_nxt = imem_addr;
        end else begin
            if (drop && imem_ready) begin
                drop_nxt = 1'b0;
            end

            case (state)
                FETCH: begin
                    if (accept) begin
                        if (if_en) begin
                            deliver      = 1'b1;
                            deliver_word = imem_data;
                        end else begin
                            hold_buf_nxt = imem_data;
                            state_nxt    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (if_en) begin
                        deliver      = 1'b1;
                        deliver_word = hold_buf;
                    end
                end
                default: ;  // HALTED: wait for a branch
            endcase

            if (deliver) begin
                instr_nxt  = deliver_word;
                pc_inc_nxt = pc + 16'd2;
                valid_nxt  = 1'b1;
                pc_nxt     = pc + 16'd2;
                state_nxt  = (deliver_word[15:11] == 5'b00000) ? HALTED : FETCH;
            end else if (if_en) begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end
        end
    end

    // State and IF/ID registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            drop_addr <= '0;
            hold_buf  <= '0;
            started   <= 1'b0;
            instr_ID  <= NOP_INSTR;
            PC_inc_ID <= 16'h0000;
            valid_ID  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            pc        <= pc_nxt;
            drop      <= drop_nxt;
            drop_addr <= drop_addr_nxt;
            hold_buf  <= hold_buf_nxt;
            started   <= 1'b1;
            instr_ID  <= instr_nxt;
            PC_inc_ID <= pc_inc_nxt;
            valid_ID  <= valid_nxt;
        end
    end

endmodule
